uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_STREAM,
        ST_RELEASE
    } state_t;

    localparam logic [7:0]  HEADER_BASE = 8'hA0;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from last+1, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = IDX_W'((int'(last) + i) % int'(N_REQ));
            if (!any && req[cand]) begin
                any  = 1'b1;
                idx  = cand;
                pick = N_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N byte-stream requesters onto one UART transmitter, with optional
// channel header, burst limit, stall timeout and post-timeout line flush.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned HEADER_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [8*N_REQ-1:0]     req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_req,
    input  logic                   tx_cts,
    input  logic                   tx_idle,
    output logic [N_REQ-1:0]       grant,
    output logic                   err_timeout
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [IDX_W-1:0] owner, owner_n, last_owner, last_owner_n;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_n, wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0] burst_inc, wait_inc;
    logic             flush, flush_n, err_timeout_n;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic [BYTE_W-1:0] data_arr [N_REQ];
    logic              own_valid, own_last;
    logic [BYTE_W-1:0] own_data;

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
        assign data_arr[g] = req_data[BYTE_W*g +: BYTE_W];
    end

    assign own_valid = req_valid[owner];
    assign own_last  = req_last[owner];
    assign own_data  = data_arr[owner];
    assign burst_inc = burst_cnt + CNT_W'(1);
    assign wait_inc  = wait_cnt + CNT_W'(1);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_owner),
        .pick  (pick),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            owner       <= '0;
            last_owner  <= IDX_W'(N_REQ - 1);
            burst_cnt   <= '0;
            wait_cnt    <= '0;
            flush       <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            owner       <= owner_n;
            last_owner  <= last_owner_n;
            burst_cnt   <= burst_cnt_n;
            wait_cnt    <= wait_cnt_n;
            flush       <= flush_n;
            err_timeout <= err_timeout_n;
        end
    end

    // Next state plus the combinational transmit/ready handshake.
    always_comb begin
        state_n       = state;
        grant_n       = grant;
        owner_n       = owner;
        last_owner_n  = last_owner;
        burst_cnt_n   = burst_cnt;
        wait_cnt_n    = wait_cnt;
        flush_n       = flush;
        err_timeout_n = 1'b0;
        tx_data       = '0;
        tx_req        = 1'b0;
        req_ready     = '0;

        unique case (state)
            ST_IDLE: begin
                if (tx_idle) flush_n = 1'b0;
                // After a timeout, hold off new owners until the line drains.
                if (pick_any && (!flush || tx_idle)) begin
                    grant_n = pick;
                    owner_n = pick_idx;
                    state_n = (HEADER_EN != 0) ? ST_HEADER : ST_STREAM;
                end
            end
            ST_HEADER: begin
                tx_data = HEADER_BASE | BYTE_W'(owner);
                tx_req  = tx_cts;
                if (tx_cts) state_n = ST_STREAM;
            end
            ST_STREAM: begin
                tx_data          = own_data;
                req_ready[owner] = tx_cts;
                tx_req           = own_valid && tx_cts;
                if (own_valid && tx_cts) begin
                    burst_cnt_n = burst_inc;
                    wait_cnt_n  = '0;
                    if (own_last || burst_inc == CNT_W'(MAX_BURST)) begin
                        state_n = ST_RELEASE;
                        grant_n = '0;
                    end
                end else if (!own_valid) begin
                    wait_cnt_n = wait_inc;
                    if (wait_inc == CNT_W'(TIMEOUT)) begin
                        state_n       = ST_RELEASE;
                        grant_n       = '0;
                        err_timeout_n = 1'b1;
                        flush_n       = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                grant_n      = '0;
                last_owner_n = owner;
                burst_cnt_n  = '0;
                wait_cnt_n   = '0;
                state_n      = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
